// File: rtl/imem_loader.sv
// Packs a little-endian byte stream into words and writes them to instruction memory; holds core reset until done.
// Latency: IM_DATA_BYTES+1 cycles per word at full rate, first byte accepted one cycle after start.
// Backpressure: o_byte_ready is high only in COLLECT; bytes offered during WRITE wait for the next COLLECT cycle.
module imem_loader #(
    parameter int IM_DEPTH      = 2048,
    parameter int IM_ADDR_WIDTH = $clog2(IM_DEPTH),
    parameter int IM_DATA_WIDTH = 32,
    parameter int IM_DATA_BYTES = IM_DATA_WIDTH / 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    input  logic                     i_abort,
    input  logic [IM_ADDR_WIDTH-1:0] i_base_addr,
    input  logic [IM_ADDR_WIDTH:0]   i_len,
    input  logic                     i_byte_valid,
    input  logic [7:0]               i_byte_data,
    output logic                     o_byte_ready,
    output logic [IM_ADDR_WIDTH-1:0] o_mem_addr,
    output logic [IM_DATA_WIDTH-1:0] o_mem_wdata,
    output logic [IM_DATA_BYTES-1:0] o_mem_wen,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_core_rst_n
);

    localparam int BIDX_W = (IM_DATA_BYTES > 1) ? $clog2(IM_DATA_BYTES) : 1;
    localparam logic [IM_ADDR_WIDTH-1:0] LAST_ADDR = IM_ADDR_WIDTH'(IM_DEPTH - 1);
    localparam logic [BIDX_W-1:0]        LAST_BYTE = BIDX_W'(IM_DATA_BYTES - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    state_t                   state_q, state_d;
    logic [IM_ADDR_WIDTH:0]   len_q, cnt_q, cnt_inc;
    logic [BIDX_W-1:0]        bidx_q;
    logic [IM_ADDR_WIDTH-1:0] addr_q;
    logic [IM_DATA_WIDTH-1:0] wdata_q;
    logic                     core_rst_n_q;
    logic                     byte_xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        byte_xfer    = 1'b0;
        cnt_inc      = cnt_q + 1'b1;
        o_byte_ready = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        o_mem_wen    = '0;
        case (state_q)
            IDLE: begin
                if (i_start) state_d = (i_len == '0) ? DONE : COLLECT;
            end
            COLLECT: begin
                o_byte_ready = 1'b1;
                o_busy       = 1'b1;
                if (i_abort) begin
                    state_d = IDLE;
                end else if (i_byte_valid) begin
                    byte_xfer = 1'b1;
                    if (bidx_q == LAST_BYTE) state_d = WRITE;
                end
            end
            WRITE: begin
                o_busy    = 1'b1;
                o_mem_wen = '1;
                if (i_abort)               state_d = IDLE;
                else if (cnt_inc == len_q) state_d = DONE;
                else                       state_d = COLLECT;
            end
            DONE: begin
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q        <= '0;
            cnt_q        <= '0;
            bidx_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            core_rst_n_q <= 1'b0;
        end else begin
            // Core leaves reset on entry to DONE so it is already high during the o_done cycle.
            if (state_d == DONE)                core_rst_n_q <= 1'b1;
            else if (state_q == IDLE && i_start) core_rst_n_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        addr_q <= i_base_addr;
                        len_q  <= i_len;
                        cnt_q  <= '0;
                        bidx_q <= '0;
                    end
                end
                COLLECT: begin
                    if (i_abort) begin
                        bidx_q <= '0;
                    end else if (byte_xfer) begin
                        for (int k = 0; k < IM_DATA_BYTES; k++) begin
                            if (bidx_q == BIDX_W'(k)) wdata_q[8*k +: 8] <= i_byte_data;
                        end
                        bidx_q <= (bidx_q == LAST_BYTE) ? '0 : bidx_q + 1'b1;
                    end
                end
                WRITE: begin
                    // An aborted load keeps its address and count; the next start reloads both.
                    if (!i_abort) begin
                        addr_q <= (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
                        cnt_q  <= cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_mem_addr   = addr_q;
    assign o_mem_wdata  = wdata_q;
    assign o_core_rst_n = core_rst_n_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scoreboard of expected memory writes plus a behavioural memory for readback.
module tb_imem_loader;

    localparam int DEPTH = 2048;
    localparam int AW    = 11;
    localparam int LW    = AW + 1;
    localparam int DW    = 32;
    localparam int NB    = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic [AW-1:0] i_base_addr = '0;
    logic [LW-1:0] i_len = '0;
    logic          i_byte_valid = 1'b0;
    logic [7:0]    i_byte_data = '0;
    logic          o_byte_ready;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic [NB-1:0] o_mem_wen;
    logic          o_busy;
    logic          o_done;
    logic          o_core_rst_n;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;
    int held_write = 0;
    wr_t sb[$];
    wr_t exp_w;
    logic [7:0] byte_q[$];
    logic [DW-1:0] mem [DEPTH];

    imem_loader #(.IM_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_base_addr  (i_base_addr),
        .i_len        (i_len),
        .i_byte_valid (i_byte_valid),
        .i_byte_data  (i_byte_data),
        .o_byte_ready (o_byte_ready),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_wen    (o_mem_wen),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_core_rst_n (o_core_rst_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk) begin
        for (int k = 0; k < NB; k++)
            if (o_mem_wen[k] === 1'b1) mem[o_mem_addr][8*k +: 8] <= o_mem_wdata[8*k +: 8];
    end

    // Write and done monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_mem_wen !== '0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr=%0d data=%h wen=%h, required no write", o_mem_addr, o_mem_wdata, o_mem_wen);
                end else begin
                    exp_w = sb.pop_front();
                    if (o_mem_addr !== exp_w.addr || o_mem_wdata !== exp_w.data || o_mem_wen !== 4'hF) begin
                        errors++;
                        $display("FAIL write: got addr=%0d data=%h wen=%h, required addr=%0d data=%h wen=f",
                                 o_mem_addr, o_mem_wdata, o_mem_wen, exp_w.addr, exp_w.data);
                    end
                end
                checks++;
                if (o_byte_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_in_write: got %b, required 0", o_byte_ready);
                end
            end
            if (o_done === 1'b1) begin
                done_cnt++;
                last_done_cyc = cyc;
                checks++;
                if (o_core_rst_n !== 1'b1) begin
                    errors++;
                    $display("FAIL core_rst_at_done: got %b, required 1", o_core_rst_n);
                end
            end
        end
    end

    task automatic send_bytes(input int max_gap);
        for (int i = 0; i < byte_q.size(); i++) begin
            int g;
            int t;
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            i_byte_valid = 1'b0;
            repeat (g) @(negedge clk);
            i_byte_valid = 1'b1;
            i_byte_data  = byte_q[i];
            t = 0;
            while (o_byte_ready !== 1'b1 && t < 50) begin
                if (o_mem_wen !== '0) held_write++;
                @(negedge clk);
                t++;
            end
            if (o_byte_ready !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL byte_timeout: byte %0d ready=%b, required 1", i, o_byte_ready);
            end
            @(negedge clk);
        end
        i_byte_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int t;
        t = 0;
        while (done_cnt == d0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL done_timeout: done pulses=%0d, required %0d", done_cnt - d0, 1);
        end
    endtask

    task automatic run_load(input logic [AW-1:0] base, input int len, input int max_gap);
        int d0;
        int sc;
        logic [DW-1:0] w_exp;
        logic [AW-1:0] a_exp;
        for (int w = 0; w < len; w++) begin
            wr_t e;
            e.addr = AW'((int'(base) + w) % DEPTH);
            e.data = {byte_q[4*w+3], byte_q[4*w+2], byte_q[4*w+1], byte_q[4*w]};
            sb.push_back(e);
        end
        d0 = done_cnt;
        @(negedge clk);
        i_start = 1'b1;
        i_base_addr = base;
        i_len = LW'(len);
        sc = cyc;
        @(negedge clk);
        i_start = 1'b0;
        if (len > 0) begin
            checks++;
            if (o_core_rst_n !== 1'b0 || o_busy !== 1'b1 || o_byte_ready !== 1'b1) begin
                errors++;
                $display("FAIL start_state: got core_rst_n=%b busy=%b ready=%b, required 0 1 1", o_core_rst_n, o_busy, o_byte_ready);
            end
        end
        send_bytes(max_gap);
        wait_done(d0);
        if (max_gap == 0) begin
            checks++;
            if (last_done_cyc - sc != len * (NB + 1) + 1) begin
                errors++;
                $display("FAIL done_latency: got %0d cycles, required %0d", last_done_cyc - sc, len * (NB + 1) + 1);
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (done_cnt != d0 + 1 || sb.size() != 0 || o_core_rst_n !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL load_end: got done=%0d pending=%0d core_rst_n=%b busy=%b, required 1 0 1 0",
                     done_cnt - d0, sb.size(), o_core_rst_n, o_busy);
        end
        for (int w = 0; w < len; w++) begin
            a_exp = AW'((int'(base) + w) % DEPTH);
            w_exp = {byte_q[4*w+3], byte_q[4*w+2], byte_q[4*w+1], byte_q[4*w]};
            checks++;
            if (mem[a_exp] !== w_exp) begin
                errors++;
                $display("FAIL readback: addr=%0d got %h, required %h", a_exp, mem[a_exp], w_exp);
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({o_byte_ready, o_mem_addr, o_mem_wdata, o_mem_wen, o_busy, o_done, o_core_rst_n} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b addr=%h data=%h wen=%h busy=%b done=%b core=%b, required all 0",
                     o_byte_ready, o_mem_addr, o_mem_wdata, o_mem_wen, o_busy, o_done, o_core_rst_n);
        end
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({o_byte_ready, o_busy, o_done, o_mem_wen, o_core_rst_n} !== '0) begin
            errors++;
            $display("FAIL reset_idle: got ready=%b busy=%b done=%b wen=%h core=%b, required all 0",
                     o_byte_ready, o_busy, o_done, o_mem_wen, o_core_rst_n);
        end
    endtask

    task automatic test_two_word;
        held_write = 0;
        byte_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_load(AW'(0), 2, 0);
        checks++;
        if (held_write == 0) begin
            errors++;
            $display("FAIL held_in_write: got %0d held cycles, required at least 1", held_write);
        end
    endtask

    task automatic test_backpressure;
        byte_q.delete();
        for (int i = 0; i < 3 * NB; i++) byte_q.push_back(8'($urandom));
        run_load(AW'(500), 3, 3);
    endtask

    task automatic test_wrap;
        byte_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_load(AW'(2047), 2, 0);
    endtask

    task automatic test_empty;
        byte_q.delete();
        run_load(AW'(10), 0, 0);
    endtask

    task automatic test_abort;
        int d0;
        d0 = done_cnt;
        @(negedge clk);
        i_start = 1'b1;
        i_base_addr = AW'(100);
        i_len = LW'(1);
        @(negedge clk);
        i_start = 1'b0;
        byte_q = '{8'hEE, 8'hFF};
        send_bytes(0);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_byte_ready !== 1'b0 || o_core_rst_n !== 1'b0 || done_cnt != d0) begin
            errors++;
            $display("FAIL abort: got busy=%b ready=%b core=%b done=%0d, required 0 0 0 0",
                     o_busy, o_byte_ready, o_core_rst_n, done_cnt - d0);
        end
        byte_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_load(AW'(100), 1, 0);

        // Reset arriving in the middle of a word
        @(negedge clk);
        i_start = 1'b1;
        i_base_addr = AW'(300);
        i_len = LW'(1);
        @(negedge clk);
        i_start = 1'b0;
        byte_q = '{8'h5A, 8'hA5};
        send_bytes(0);
        checks++;
        if (o_busy !== 1'b1 || o_mem_addr !== AW'(300)) begin
            errors++;
            $display("FAIL midword_pre: got busy=%b addr=%0d, required 1 300", o_busy, o_mem_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({o_byte_ready, o_mem_addr, o_mem_wdata, o_mem_wen, o_busy, o_done, o_core_rst_n} !== '0) begin
            errors++;
            $display("FAIL midword_reset: got ready=%b addr=%h data=%h wen=%h busy=%b done=%b core=%b, required all 0",
                     o_byte_ready, o_mem_addr, o_mem_wdata, o_mem_wen, o_busy, o_done, o_core_rst_n);
        end
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        byte_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load(AW'(301), 1, 0);
    endtask

    initial begin
        #12 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        test_two_word();
        test_backpressure();
        test_wrap();
        test_empty();
        test_abort();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycles=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
